// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM for a multicycle MIPS-subset datapath. It sequences fetch,
// decode, execute, memory and write-back over the shared ALU, memory port and
// register file. It stalls on a single-bit memory ready handshake and flags
// unsupported encodings.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   opcode, funct       IR[31:26] / IR[5:0]; opcode is valid from DECODE on
//   zero                ALU zero flag, used by beq/bne
//   mem_ready           memory completes the current access this cycle
//   pc_we, ir_we        PC / IR write enables (Mealy)
//   reg_we              register file write enable
//   mem_re, mem_we      memory read / write strobes
//   iord                memory address select: 0=PC, 1=ALUOut
//   reg_dst             destination register: 0=rt, 1=rd
//   wb_sel              write-back source: 0=ALUOut, 1=MDR
//   alu_src_a           ALU A: 0=PC, 1=reg A
//   alu_src_b           ALU B: 0=reg B, 1=4, 2=ext imm, 3=ext imm<<2
//   alu_op              000 add, 001 sub, 010 and, 011 or, 100 slt, 101 pass B
//   pc_src              PC source: 0=ALU result, 1=ALUOut, 2=jump target
//   ext_sel             immediate extender: 0=sign, 1=zero, 2=upper
//   illegal             one-cycle pulse on an unsupported encoding (Mealy)
//   retired             one-cycle pulse on the last cycle of an instruction
//   state               current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_dst,
    output logic       wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] ext_sel,
    output logic       illegal,
    output logic       retired,
    output logic [3:0] state
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    // ALU operations
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_PASS = 3'b101;

    // Mux selects
    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;
    localparam logic [1:0] PC_ALU      = 2'd0;
    localparam logic [1:0] PC_ALUOUT   = 2'd1;
    localparam logic [1:0] PC_JUMP     = 2'd2;
    localparam logic [1:0] EXT_SIGN    = 2'd0;
    localparam logic [1:0] EXT_ZERO    = 2'd1;
    localparam logic [1:0] EXT_UPPER   = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_ALU_WB   = 4'd7,
        S_I_EXEC   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    // Bundle of every control output so one default clears them all
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic       iord;
        logic       reg_dst;
        logic       wb_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] ext_sel;
        logic       illegal;
        logic       retired;
    } ctrl_t;

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] funct_q;
    ctrl_t           ctrl_c;

    // Supported R-type function codes
    function automatic logic funct_legal(input logic [OP_W-1:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_legal = 1'b1;
            default:                               funct_legal = 1'b0;
        endcase
    endfunction

    // State entered after DECODE; FETCH means the encoding is unsupported
    function automatic state_t decode_target(input logic [OP_W-1:0] op,
                                             input logic [OP_W-1:0] fn);
        case (op)
            OP_RTYPE:                         decode_target = funct_legal(fn) ? S_R_EXEC : S_FETCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: decode_target = S_I_EXEC;
            OP_LW, OP_SW:                     decode_target = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   decode_target = S_BRANCH;
            OP_J:                             decode_target = S_JUMP;
            default:                          decode_target = S_FETCH;
        endcase
    endfunction

    // ALU operation for an R-type function code
    function automatic logic [2:0] funct_alu_op(input logic [OP_W-1:0] fn);
        case (fn)
            FN_SUB:  funct_alu_op = ALU_SUB;
            FN_AND:  funct_alu_op = ALU_AND;
            FN_OR:   funct_alu_op = ALU_OR;
            FN_SLT:  funct_alu_op = ALU_SLT;
            default: funct_alu_op = ALU_ADD;
        endcase
    endfunction

    // State register; opcode/funct are latched as DECODE is left
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        ctrl_c  = '0;

        case (state_q)
            S_FETCH: begin
                ctrl_c.mem_re    = 1'b1;
                ctrl_c.iord      = 1'b0;
                ctrl_c.alu_src_a = 1'b0;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.pc_src    = PC_ALU;
                ctrl_c.ir_we     = mem_ready;
                ctrl_c.pc_we     = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            // Speculatively form the branch target into ALUOut
            S_DECODE: begin
                ctrl_c.alu_src_a = 1'b0;
                ctrl_c.alu_src_b = SRCB_IMM_SH;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.ext_sel   = EXT_SIGN;
                state_d          = decode_target(opcode, funct);
                ctrl_c.illegal   = (decode_target(opcode, funct) == S_FETCH);
            end

            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.ext_sel   = EXT_SIGN;
                state_d          = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                ctrl_c.mem_re = 1'b1;
                ctrl_c.iord   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                ctrl_c.reg_we  = 1'b1;
                ctrl_c.reg_dst = 1'b0;
                ctrl_c.wb_sel  = 1'b1;
                ctrl_c.retired = 1'b1;
                state_d        = S_FETCH;
            end

            // mem_we stays high across the stall until memory accepts
            S_MEM_WR: begin
                ctrl_c.mem_we = 1'b1;
                ctrl_c.iord   = 1'b1;
                if (mem_ready) begin
                    ctrl_c.retired = 1'b1;
                    state_d        = S_FETCH;
                end
            end

            S_R_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.alu_op    = funct_alu_op(funct_q);
                state_d          = S_ALU_WB;
            end

            S_I_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                case (op_q)
                    OP_ANDI: begin
                        ctrl_c.alu_op  = ALU_AND;
                        ctrl_c.ext_sel = EXT_ZERO;
                    end
                    OP_ORI: begin
                        ctrl_c.alu_op  = ALU_OR;
                        ctrl_c.ext_sel = EXT_ZERO;
                    end
                    OP_LUI: begin
                        ctrl_c.alu_op  = ALU_PASS;
                        ctrl_c.ext_sel = EXT_UPPER;
                    end
                    default: begin
                        ctrl_c.alu_op  = ALU_ADD;
                        ctrl_c.ext_sel = EXT_SIGN;
                    end
                endcase
                state_d = S_ALU_WB;
            end

            S_ALU_WB: begin
                ctrl_c.reg_we  = 1'b1;
                ctrl_c.wb_sel  = 1'b0;
                ctrl_c.reg_dst = (op_q == OP_RTYPE);
                ctrl_c.retired = 1'b1;
                state_d        = S_FETCH;
            end

            // Compare via subtract; bne takes the branch on a nonzero result
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.alu_op    = ALU_SUB;
                ctrl_c.pc_src    = PC_ALUOUT;
                ctrl_c.pc_we     = (op_q == OP_BNE) ? ~zero : zero;
                ctrl_c.retired   = 1'b1;
                state_d          = S_FETCH;
            end

            S_JUMP: begin
                ctrl_c.pc_src  = PC_JUMP;
                ctrl_c.pc_we   = 1'b1;
                ctrl_c.retired = 1'b1;
                state_d        = S_FETCH;
            end

            // Unused encodings recover to FETCH
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset overrides everything, including FETCH's strobes
        if (reset) begin
            ctrl_c = '0;
        end
    end

    assign pc_we     = ctrl_c.pc_we;
    assign ir_we     = ctrl_c.ir_we;
    assign reg_we    = ctrl_c.reg_we;
    assign mem_re    = ctrl_c.mem_re;
    assign mem_we    = ctrl_c.mem_we;
    assign iord      = ctrl_c.iord;
    assign reg_dst   = ctrl_c.reg_dst;
    assign wb_sel    = ctrl_c.wb_sel;
    assign alu_src_a = ctrl_c.alu_src_a;
    assign alu_src_b = ctrl_c.alu_src_b;
    assign alu_op    = ctrl_c.alu_op;
    assign pc_src    = ctrl_c.pc_src;
    assign ext_sel   = ctrl_c.ext_sel;
    assign illegal   = ctrl_c.illegal;
    assign retired   = ctrl_c.retired;
    assign state     = STATE_W'(state_q);

endmodule
